// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for the 3-stage core (pc -> if_id -> id_ex -> ex).
// Turns jump, bus-stall, ex-stall and load-use requests into per-stage
// hold / NOP-flush controls and the pc redirect, with zero-cycle latency.
// Optional feature macro: PIPE_CTRL_PERF_EN adds saturating flush/stall
// cycle counters and their perf_flush_o / perf_stall_o ports.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              stall_bus_i,
  input  logic              stall_ex_i,
  input  logic              load_use_i,
  output logic              pc_hold_o,
  output logic              if_id_hold_o,
  output logic              if_id_flush_o,
  output logic              id_ex_hold_o,
  output logic              id_ex_flush_o,
  output logic              jump_en_o,
  output logic [ADDR_W-1:0] jump_addr_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_flush_o,
  output logic [31:0]       perf_stall_o
`endif
);

  // Counter only needs to hold FLUSH_CYCLES-1 down to 1.
  localparam int CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    BSTALL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  state_t              saved_q, saved_d;
  state_t              eff_state;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic                fire;
  logic [ADDR_W-1:0]   fire_addr;

  // State, saved state, flush counter and pending redirect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      saved_q     <= RUN;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  // Request arbitration: bus stall > jump (live or pending) > ex stall > load-use.
  // The cycle a bus stall ends behaves as the state saved when it began, so a
  // stall is transparent to the flush sequence.
  always_comb begin
    state_d       = state_q;
    saved_d       = saved_q;
    cnt_d         = cnt_q;
    pend_d        = pend_q;
    pend_addr_d   = pend_addr_q;
    pc_hold_o     = 1'b0;
    if_id_hold_o  = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_hold_o  = 1'b0;
    id_ex_flush_o = 1'b0;
    jump_en_o     = 1'b0;
    jump_addr_o   = '0;
    fire          = 1'b0;
    fire_addr     = '0;
    eff_state     = (state_q == BSTALL) ? saved_q : state_q;

    if (!rst_n) begin
      state_d = RUN;
    end else if (stall_bus_i) begin
      pc_hold_o    = 1'b1;
      if_id_hold_o = 1'b1;
      id_ex_hold_o = 1'b1;
      state_d      = BSTALL;
      if (state_q != BSTALL) saved_d = state_q;
      if (jump_en_i) begin
        pend_d      = 1'b1;
        pend_addr_d = jump_addr_i;
      end
    end else begin
      if (jump_en_i) begin
        fire      = 1'b1;
        fire_addr = jump_addr_i;
      end else if (state_q == BSTALL && pend_q) begin
        fire      = 1'b1;
        fire_addr = pend_addr_q;
      end
      pend_d  = 1'b0;
      state_d = eff_state;

      if (fire) begin
        jump_en_o     = 1'b1;
        jump_addr_o   = fire_addr;
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end else begin
          state_d = RUN;
        end
      end else begin
        case (eff_state)
          FLUSH: begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            cnt_d         = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = RUN;
          end
          default: begin
            state_d = RUN;
            if (stall_ex_i || load_use_i) begin
              pc_hold_o     = 1'b1;
              if_id_hold_o  = 1'b1;
              id_ex_flush_o = 1'b1;
            end
          end
        endcase
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Saturating counters of flush cycles and pc-hold cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_flush_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (if_id_flush_o && perf_flush_o != 32'hFFFF_FFFF) perf_flush_o <= perf_flush_o + 1'b1;
      if (pc_hold_o && perf_stall_o != 32'hFFFF_FFFF) perf_stall_o <= perf_stall_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus randomized traffic for pipe_ctrl,
// checked every cycle against a behavioural model of owed flush cycles and
// a pending redirect.
module tb_pipe_ctrl;

  localparam int FC = 2;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          jump_en_i;
  logic [AW-1:0] jump_addr_i;
  logic          stall_bus_i;
  logic          stall_ex_i;
  logic          load_use_i;
  logic          pc_hold_o;
  logic          if_id_hold_o;
  logic          if_id_flush_o;
  logic          id_ex_hold_o;
  logic          id_ex_flush_o;
  logic          jump_en_o;
  logic [AW-1:0] jump_addr_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]   perf_flush_o;
  logic [31:0]   perf_stall_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: flush cycles still owed, pending redirect, perf counts.
  int            m_flush_left = 0;
  bit            m_pend = 1'b0;
  logic [AW-1:0] m_pend_addr = '0;
  longint        m_perf_flush = 0;
  longint        m_perf_stall = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .jump_en_i     (jump_en_i),
    .jump_addr_i   (jump_addr_i),
    .stall_bus_i   (stall_bus_i),
    .stall_ex_i    (stall_ex_i),
    .load_use_i    (load_use_i),
    .pc_hold_o     (pc_hold_o),
    .if_id_hold_o  (if_id_hold_o),
    .if_id_flush_o (if_id_flush_o),
    .id_ex_hold_o  (id_ex_hold_o),
    .id_ex_flush_o (id_ex_flush_o),
    .jump_en_o     (jump_en_o),
    .jump_addr_o   (jump_addr_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_flush_o  (perf_flush_o),
    .perf_stall_o  (perf_stall_o)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check just before the
  // rising edge, then advance the model to the next cycle.
  task automatic applyStimulus(input string tag, input logic rst, input logic jmp,
                               input logic [AW-1:0] addr, input logic bus,
                               input logic ex, input logic lu);
    logic [5:0]    exp_ctl;
    logic [AW-1:0] exp_addr;
    logic [5:0]    obs_ctl;
    @(negedge clk);
    rst_n       = rst;
    jump_en_i   = jmp;
    jump_addr_i = addr;
    stall_bus_i = bus;
    stall_ex_i  = ex;
    load_use_i  = lu;
    #4;
    // control vector: {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, jump_en}
    exp_ctl  = 6'b000000;
    exp_addr = '0;
    if (!rst) begin
      m_flush_left = 0;
      m_pend       = 1'b0;
      m_pend_addr  = '0;
      m_perf_flush = 0;
      m_perf_stall = 0;
    end else if (bus) begin
      exp_ctl = 6'b110100;
      if (jmp) begin
        m_pend      = 1'b1;
        m_pend_addr = addr;
      end
    end else if (jmp || m_pend) begin
      exp_ctl      = 6'b001011;
      exp_addr     = jmp ? addr : m_pend_addr;
      m_pend       = 1'b0;
      m_flush_left = FC - 1;
    end else if (m_flush_left > 0) begin
      exp_ctl = 6'b001010;
      m_flush_left--;
    end else if (ex || lu) begin
      exp_ctl = 6'b110010;
    end
    obs_ctl = {pc_hold_o, if_id_hold_o, if_id_flush_o, id_ex_hold_o, id_ex_flush_o, jump_en_o};
    checkOutput({tag, "/ctl"}, 64'(obs_ctl), 64'(exp_ctl));
    checkOutput({tag, "/addr"}, 64'(jump_addr_o), 64'(exp_addr));
`ifdef PIPE_CTRL_PERF_EN
    checkOutput({tag, "/perf_flush"}, 64'(perf_flush_o), 64'(m_perf_flush));
    checkOutput({tag, "/perf_stall"}, 64'(perf_stall_o), 64'(m_perf_stall));
`endif
    if (rst) begin
      if (exp_ctl[3] && m_perf_flush < 64'hFFFF_FFFF) m_perf_flush++;
      if (exp_ctl[5] && m_perf_stall < 64'hFFFF_FFFF) m_perf_stall++;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    jump_en_i   = 1'b0;
    jump_addr_i = '0;
    stall_bus_i = 1'b0;
    stall_ex_i  = 1'b0;
    load_use_i  = 1'b0;

    // Reset held with toggling inputs, then release with no requests.
    for (int i = 0; i < 4; i++)
      applyStimulus("rst_hold", 1'b0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 3; i++)
      applyStimulus("idle", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Single redirect to 0x100.
    applyStimulus("jump", 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus("jump_tail", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Bus stall for 4 cycles with a redirect latched in cycle 2.
    for (int i = 0; i < 4; i++)
      applyStimulus("bus_stall", 1'b1, i == 1, 32'h0000_0200, 1'b1, 1'b0, 1'b0);
    applyStimulus("bus_release", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus("bus_tail", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Multi-cycle ex op.
    for (int i = 0; i < 5; i++)
      applyStimulus("ex_stall", 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++)
      applyStimulus("ex_tail", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Jump beats load-use, then a bus stall in the middle of the flush.
    applyStimulus("jump_vs_lu", 1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus("flush_bus", 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus("flush_resume", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Reset while a redirect is pending: nothing fires afterwards.
    applyStimulus("pend_set", 1'b1, 1'b1, 32'h0000_0400, 1'b1, 1'b0, 1'b0);
    applyStimulus("pend_hold", 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus("pend_rst", 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus("post_rst", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      applyStimulus("rand", $urandom_range(0, 199) != 0,
                    $urandom_range(0, 9) == 0, $urandom,
                    $urandom_range(0, 6) == 0,
                    $urandom_range(0, 5) == 0,
                    $urandom_range(0, 5) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
